// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the two-requester logic-unit arbiter: op codes,
// FSM state encoding and default widths.
package logic_unit_arbiter_pkg;

  localparam int DATA_SIZE_DEF    = 8;
  localparam int OP_CODE_SIZE_DEF = 2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/logic_unit_arbiter_d1.sv
// Shared bitwise datapath: purely combinational AND/OR/XOR/NOT on data_size bits.
// Op codes outside the defined set produce zero.
module logic_unit_d1
  import logic_unit_arbiter_pkg::*;
#(
  parameter int data_size    = DATA_SIZE_DEF,
  parameter int op_code_size = OP_CODE_SIZE_DEF
) (
  input  logic [data_size-1:0]    a_in,
  input  logic [data_size-1:0]    b_in,
  input  logic [op_code_size-1:0] op_code,
  output logic [data_size-1:0]    result_out
);

  always_comb begin
    result_out = '0;
    case (op_code)
      op_code_size'(OP_AND): result_out = a_in & b_in;
      op_code_size'(OP_OR):  result_out = a_in | b_in;
      op_code_size'(OP_XOR): result_out = a_in ^ b_in;
      op_code_size'(OP_NOT): result_out = ~a_in;
      default:               result_out = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter for two requesters sharing one logic unit; IDLE->EXEC->RESP,
// response two edges after accept, held in RESP until rsp_ready (no new accepts meanwhile).
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int data_size    = DATA_SIZE_DEF,
  parameter int op_code_size = OP_CODE_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [data_size-1:0]    req0_a,
  input  logic [data_size-1:0]    req0_b,
  input  logic [op_code_size-1:0] req0_op,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [data_size-1:0]    req1_a,
  input  logic [data_size-1:0]    req1_b,
  input  logic [op_code_size-1:0] req1_op,
  output logic                    req1_ready,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [data_size-1:0]    rsp_data,
  input  logic                    rsp_ready,
  output logic                    busy
);

  logic [1:0]              state_q, state_d;
  logic                    last_q, last_d;
  logic [data_size-1:0]    a_q, a_d;
  logic [data_size-1:0]    b_q, b_d;
  logic [op_code_size-1:0] op_q, op_d;
  logic                    id_q, id_d;
  logic [data_size-1:0]    rsp_data_q, rsp_data_d;
  logic                    rsp_id_q, rsp_id_d;
  logic                    grant_vld;
  logic                    grant_id;
  logic [data_size-1:0]    lu_result;

  // Contention goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (!rst && state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_q;
      end else if (req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_vld && !grant_id;
  assign req1_ready = grant_vld && grant_id;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_EXEC;
          last_d  = grant_id;
          a_d     = grant_id ? req1_a  : req0_a;
          b_d     = grant_id ? req1_b  : req0_b;
          op_d    = grant_id ? req1_op : req0_op;
          id_d    = grant_id;
        end
      end
      ST_EXEC: begin
        state_d    = ST_RESP;
        rsp_data_d = lu_result;
        rsp_id_d   = id_q;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  logic_unit_d1 #(
    .data_size   (data_size),
    .op_code_size(op_code_size)
  ) u_lu (
    .a_in      (a_q),
    .b_in      (b_q),
    .op_code   (op_q),
    .result_out(lu_result)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: inputs driven 1ns after the rising edge,
// outputs sampled on the falling edge.
module tb_logic_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_ready, busy;
  logic [7:0] rsp_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req0_op   (req0_op),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .req1_op   (req1_op),
    .req1_ready(req1_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  int gid[6];
  int gcyc[6];
  int n;
  int r;

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;

    // Reset state, and no ready while reset is high
    repeat (2) @(posedge clk);
    smp();
    check("rst_rdy0", 32'(req0_ready), 0);
    cyc(); rst = 1'b0; req0_valid = 1'b0;
    smp();
    check("rst_vld",  32'(rsp_valid), 0);
    check("rst_data", 32'(rsp_data), 'h00);
    check("rst_id",   32'(rsp_id), 0);
    check("rst_busy", 32'(busy), 0);

    // Single request: F0 AND 3C = 30; inputs scrambled after accept
    cyc(); req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b00;
    smp();
    check("t1_rdy0", 32'(req0_ready), 1);
    check("t1_rdy1", 32'(req1_ready), 0);
    cyc(); req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_op = 2'b11;
    smp();
    check("t1_exec_busy", 32'(busy), 1);
    check("t1_exec_vld",  32'(rsp_valid), 0);
    check("t1_exec_rdy0", 32'(req0_ready), 0);
    cyc(); smp();
    check("t1_vld",  32'(rsp_valid), 1);
    check("t1_data", 32'(rsp_data), 'h30);
    check("t1_id",   32'(rsp_id), 0);
    cyc(); smp();
    check("t1_done_vld",  32'(rsp_valid), 0);
    check("t1_done_busy", 32'(busy), 0);

    // Contention after reset: req0 (0F XOR 33 = 3C) first, then req1 (AA OR 55 = FF)
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'h33; req0_op = 2'b10;
    req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55; req1_op = 2'b01;
    smp();
    check("t2_rdy0", 32'(req0_ready), 1);
    check("t2_rdy1", 32'(req1_ready), 0);
    cyc(); smp();
    check("t2_exec_rdy", 32'(req0_ready | req1_ready), 0);
    cyc(); smp();
    check("t2_vld0",  32'(rsp_valid), 1);
    check("t2_data0", 32'(rsp_data), 'h3C);
    check("t2_id0",   32'(rsp_id), 0);
    cyc(); smp();
    check("t2_second_rdy1", 32'(req1_ready), 1);
    check("t2_second_rdy0", 32'(req0_ready), 0);
    cyc();
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    smp();
    check("t2_vld1",  32'(rsp_valid), 1);
    check("t2_data1", 32'(rsp_data), 'hFF);
    check("t2_id1",   32'(rsp_id), 1);
    cyc(); smp();
    check("t2_done_busy", 32'(busy), 0);

    // Fairness: both held valid, 6 accepts alternate 0,1,... 3 cycles apart
    cyc();
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h0F; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'h00; req1_op = 2'b11;
    n = 0; r = 0;
    for (int c = 0; c < 21; c++) begin
      if (c > 0) cyc();
      if (n == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      smp();
      check("fair_onehot", 32'(req0_ready & req1_ready), 0);
      if (rsp_valid) begin
        check("fair_rsp_id",   32'(rsp_id), 32'(r % 2));
        check("fair_rsp_data", 32'(rsp_data), (r % 2 == 0) ? 'h0F : 'hF0);
        r++;
      end
      if ((req0_ready || req1_ready) && n < 6) begin
        gid[n]  = req1_ready ? 1 : 0;
        gcyc[n] = c;
        n++;
      end
    end
    check("fair_accepts", 32'(n), 6);
    check("fair_rsps",    32'(r), 6);
    if (n == 6) begin
      for (int k = 0; k < 6; k++) begin
        check("fair_grant", 32'(gid[k]), 32'(k % 2));
        if (k > 0) check("fair_gap", 32'(gcyc[k] - gcyc[k-1]), 3);
      end
    end
    check("fair_idle", 32'(busy), 0);

    // Backpressure: FF XOR 0F = F0 held for 5 stalled cycles
    cyc(); rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h0F; req0_op = 2'b10;
    smp();
    check("bp_rdy0", 32'(req0_ready), 1);
    cyc(); req1_valid = 1'b1; req0_a = 8'h12; req0_op = 2'b00;
    smp();
    check("bp_exec_busy", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      cyc(); smp();
      check("bp_hold_vld",  32'(rsp_valid), 1);
      check("bp_hold_data", 32'(rsp_data), 'hF0);
      check("bp_hold_id",   32'(rsp_id), 0);
      check("bp_hold_rdy",  32'(req0_ready | req1_ready), 0);
    end
    cyc(); rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    smp();
    check("bp_rel_vld",  32'(rsp_valid), 1);
    check("bp_rel_data", 32'(rsp_data), 'hF0);
    cyc(); smp();
    check("bp_idle_busy", 32'(busy), 0);
    check("bp_idle_vld",  32'(rsp_valid), 0);

    // Reset during EXEC drops the transaction and restores req0 priority
    cyc(); req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF; req0_op = 2'b00;
    smp();
    check("rm_rdy0", 32'(req0_ready), 1);
    cyc(); rst = 1'b1; req0_valid = 1'b0;
    smp();
    check("rm_exec_busy", 32'(busy), 1);
    cyc(); rst = 1'b0;
    smp();
    check("rm_after_busy", 32'(busy), 0);
    check("rm_after_vld",  32'(rsp_valid), 0);
    check("rm_after_data", 32'(rsp_data), 'h00);
    cyc(); smp();
    check("rm_no_rsp", 32'(rsp_valid), 0);
    cyc();
    req0_valid = 1'b1; req0_a = 8'h00; req0_b = 8'h5A; req0_op = 2'b11;
    req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55; req1_op = 2'b01;
    smp();
    check("rm_rdy0", 32'(req0_ready), 1);
    check("rm_rdy1", 32'(req1_ready), 0);
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(); smp();
    check("rm_vld",  32'(rsp_valid), 1);
    check("rm_data", 32'(rsp_data), 'hFF);
    check("rm_id",   32'(rsp_id), 0);
    cyc(); smp();
    check("rm_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 The block SHALL have parameter data_size, default 8, giving the operand and result width.
REQ-002 The block SHALL have parameter op_code_size, default 2, giving the op code width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1) is the rising-edge clock, rst (input, 1) is the synchronous active-high reset.
REQ-004 The block SHALL have the following request ports, for requester n in {0,1}:
- reqn_valid (input, 1): request pending.
- reqn_a (input, data_size): operand a.
- reqn_b (input, data_size): operand b.
- reqn_op (input, op_code_size): operation.
- reqn_ready (output, 1): request accepted this cycle.
REQ-005 The block SHALL have the following response ports:
- rsp_valid (output, 1): response held.
- rsp_id (output, 1): requester index.
- rsp_data (output, data_size): result.
- rsp_ready (input, 1): consumer accepts.
REQ-006 The block SHALL have busy (output, 1), high whenever the state is not IDLE.

Function
REQ-007 The block SHALL use three states: IDLE, EXEC and RESP.
REQ-008 In IDLE with at least one reqn_valid high, the arbiter SHALL assert exactly one reqn_ready combinationally, latch that requester's a, b, op and id into internal operand registers, and go to EXEC at the next edge.
REQ-009 When both requests are valid in IDLE, the arbiter SHALL grant the requester not granted last (round-robin); a single valid requester SHALL be granted regardless of history.
REQ-010 reqn_ready SHALL be 0 in EXEC and RESP, and in IDLE for the losing or non-valid requester.
REQ-011 In EXEC, the latched operands SHALL drive the shared logic unit, its result SHALL be registered into rsp_data, and the state SHALL go to RESP.
REQ-012 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_id SHALL stay stable until a cycle with rsp_ready = 1.
REQ-013 On that rsp_ready cycle the state SHALL go to IDLE, and rsp_valid SHALL be 0 from the next cycle.
REQ-014 Latency SHALL be: accept at edge N, rsp_valid high after edge N+2; maximum throughput is one transaction per 3 cycles.
REQ-015 rsp_ready asserted outside RESP SHALL be ignored.
REQ-016 Requester inputs that change while the state is EXEC or RESP SHALL NOT affect the transaction in flight.
REQ-017 The op code semantics SHALL be: 00 = a AND b, 01 = a OR b, 10 = a XOR b, 11 = NOT a; all results are data_size wide with no carry or overflow.
REQ-018 The last-grant pointer SHALL update only on an accept, and SHALL wrap 1 -> 0 -> 1.

Reset
REQ-019 While rst = 1 at a clock edge, the state SHALL become IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, the operand registers 0, and the last-grant pointer 1, so requester 0 wins the first contention.
REQ-020 A reset during EXEC or RESP SHALL drop the in-flight transaction with no response; rsp_valid SHALL be 0 after that edge.
REQ-021 reqn_ready SHALL be 0 in any cycle where rst = 1.

Structure
REQ-022 A shared package SHALL hold the op code constants (AND, OR, XOR, NOT), the state encoding, and the default data_size and op_code_size values.
REQ-023 The block SHALL instantiate exactly one sub-module, logic_unit_d1, as the shared datapath with ports a_in, b_in, op_code and result_out.
REQ-024 The arbitration, FSM and response register SHALL reside in logic_unit_arbiter.

Verification
REQ-025 Single request: reset, then req0 with a=8'hF0, b=8'h3C, op=00 -> req0_ready for 1 cycle, rsp_valid two edges later, rsp_data=8'h30, rsp_id=0.
REQ-026 Contention: req0 and req1 both valid after reset, req1 with a=8'hAA, b=8'h55, op=01 -> req0 granted first; after its response, req1 granted with rsp_data=8'hFF, rsp_id=1.
REQ-027 Fairness: req0 and req1 held valid for 6 transactions with rsp_ready tied 1 -> grants alternate 0,1,0,1,0,1, with 3 cycles between accepts.
REQ-028 Backpressure: rsp_ready=0 for 5 cycles in RESP, with op=10, a=8'hFF, b=8'h0F -> rsp_valid and rsp_data=8'hF0 held stable, no reqn_ready asserted, and IDLE one cycle after rsp_ready=1.
REQ-029 Reset mid-operation: rst pulsed during EXEC -> no response; the next contention grants req0; NOT with a=8'h00 -> rsp_data=8'hFF.
